store_merge_unit: RTL
=====================

# store_merge_unit

Store-side companion to the immediate/load sign extender: where loads widen narrow memory data into 32-bit registers, this block narrows 32-bit register data into byte/halfword stores. It accepts sb/sh/sw requests from the MEM stage and drives a word-addressed data memory through a req/ack handshake. Word stores (sw) are a single write. Sub-word stores (sb/sh) are a read-modify-write that merges the selected byte lanes, big-endian.

## Interface
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- st_valid  in  1  store request valid
- st_ready  out  1  unit idle; request accepted when st_valid && st_ready
- st_opcode  in  6  101000 sb, 101001 sh, 101011 sw; anything else is unsupported
- st_addr  in  32  byte address
- st_data  in  32  rs2 register value; sb uses [7:0], sh uses [15:0]
- st_done  out  1  one-cycle pulse: store committed
- st_err  out  1  one-cycle pulse: request dropped, no memory write
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  32  {st_addr[31:2], 2'b00}
- mem_wdata  out  32  merged write word
- mem_ack  in  1  memory completes the current request in this cycle
- mem_rdata  in  32  read data, valid when mem_ack && !mem_we

## Operation
- FSM states: IDLE, READ, WRITE.
- IDLE: st_ready=1. On accept, latch opcode, addr and data.
  - sw: go to WRITE with mem_wdata=st_data.
  - sb/sh: go to READ.
  - Unsupported opcode: stay in IDLE and pulse st_err next cycle.
- READ: mem_req=1, mem_we=0. On mem_ack, latch merge(mem_rdata) into the wdata register and go to WRITE.
- WRITE: mem_req=1, mem_we=1. On mem_ack, go to IDLE and pulse st_done next cycle.
- Merge rules (big-endian), all other bits taken from mem_rdata:
  - sb: addr[1:0]=0 replaces [31:24], 1 replaces [23:16], 2 replaces [15:8], 3 replaces [7:0], each with data[7:0].
  - sh: addr[1]=0 replaces [31:16], 1 replaces [15:0], with data[15:0].
- mem_ack is ignored when mem_req=0.
- mem_addr and mem_wdata are stable while mem_req=1.
- st_ready=0 in READ and WRITE. New requests stall; there is no queue.

## Timing
- Reset values: state IDLE, st_ready=1, st_done=0, st_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Let C0 be the accept cycle.
  - sw: mem_req high from C1. With ack in C1, st_done is high in C2, the same cycle st_ready returns to 1. Minimum latency is 2 cycles.
  - sb/sh: read in C1, write in C2 (ack in the same cycle each time), st_done in C3. Minimum latency is 3 cycles.
  - Each cycle without mem_ack adds one cycle of latency.
- st_done and st_err are registered and never both high.
- A new request can be accepted in the same cycle st_done is high.
- Reset asserted mid-operation forces IDLE immediately (asynchronous): mem_req drops, no st_done is generated, and the partial store is abandoned. A READ interrupted this way has written nothing.

## Configuration
- STORE_ALIGN_CHECK_EN defined:
  - Misaligned requests are accepted and dropped. Misaligned means sh with addr[0]=1, or sw with addr[1:0]!=0.
  - A dropped request causes no memory traffic; st_err pulses in C1.
- STORE_ALIGN_CHECK_EN undefined:
  - sh ignores addr[0]; sw ignores addr[1:0].
  - st_err pulses only for unsupported opcodes.

## Test plan
- sw, addr 0x0000_0104, data 0xDEAD_BEEF, mem_ack in C1 -> one write to 0x104 with wdata 0xDEADBEEF; st_done in C2; no read issued.
- sb, addr 0x0000_0042, data 0x0000_00AB, mem_rdata 0x1122_3344, immediate acks -> read 0x40, then write 0x40 with 0x1122_AB44; st_done in C3.
- sh, addr 0x0000_0012, data 0xFFFF_5566, rdata 0xAABB_CCDD, 3-cycle ack delay on both phases -> write 0xAABB_5566; mem_req, mem_addr and mem_wdata held constant while waiting; st_ready=0 throughout.
- sh, addr 0x0000_0013:
  - With STORE_ALIGN_CHECK_EN: st_err in C1, mem_req never high.
  - Without it: behaves as addr 0x12.
- Opcode 6'b100011 (lw) -> st_err in C1, no mem_req, st_ready remains 1.
- Reset asserted during a WRITE wait -> mem_req=0 in the same cycle; st_done is never pulsed; the next sw is accepted and completes normally.

Source files
------------

// File: rtl/store_merge_unit.sv
// store_merge_unit: narrows register data into sb/sh/sw stores, big-endian lane merge.
// Define STORE_ALIGN_CHECK_EN to drop misaligned sh/sw requests with st_err.
module store_merge_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [5:0]  st_opcode,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   output logic        st_done,
   output logic        st_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);
   localparam logic [5:0] OP_SB = 6'b101000;
   localparam logic [5:0] OP_SH = 6'b101001;
   localparam logic [5:0] OP_SW = 6'b101011;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_is_sh;
   logic [31:0] r_addr;
   logic [15:0] r_data;
   logic [31:0] r_wdata;
   logic        r_done;
   logic        r_err;

   logic        w_accept;
   logic        w_sb;
   logic        w_sh;
   logic        w_sw;
   logic        w_misalign;
   logic        w_drop;
   logic [31:0] w_merged;

   assign w_accept = st_valid && (r_state == S_IDLE);
   assign w_sb     = (st_opcode == OP_SB);
   assign w_sh     = (st_opcode == OP_SH);
   assign w_sw     = (st_opcode == OP_SW);

`ifdef STORE_ALIGN_CHECK_EN
   assign w_misalign = (w_sh && st_addr[0]) ||
                       (w_sw && (st_addr[1:0] != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif

   assign w_drop = !(w_sb || w_sh || w_sw) || w_misalign;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept && !w_drop)
               w_next = w_sw ? S_WRITE : S_READ;
         end
         S_READ: begin
            if (mem_ack) w_next = S_WRITE;
         end
         S_WRITE: begin
            if (mem_ack) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Byte 0 of the word sits in the most significant lane.
   always_comb begin
      w_merged = mem_rdata;
      if (r_is_sh) begin
         if (r_addr[1]) w_merged[15:0]  = r_data;
         else           w_merged[31:16] = r_data;
      end else begin
         case (r_addr[1:0])
            2'd0: w_merged[31:24] = r_data[7:0];
            2'd1: w_merged[23:16] = r_data[7:0];
            2'd2: w_merged[15:8]  = r_data[7:0];
            2'd3: w_merged[7:0]   = r_data[7:0];
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_is_sh <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
         r_wdata <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= (r_state == S_WRITE) && mem_ack;
         r_err  <= w_accept && w_drop;
         if (w_accept && !w_drop) begin
            r_is_sh <= w_sh;
            r_addr  <= st_addr;
            r_data  <= st_data[15:0];
            if (w_sw) r_wdata <= st_data;
         end
         if ((r_state == S_READ) && mem_ack)
            r_wdata <= w_merged;
      end
   end

   assign st_ready  = (r_state == S_IDLE);
   assign mem_req   = (r_state != S_IDLE);
   assign mem_we    = (r_state == S_WRITE);
   assign mem_addr  = {r_addr[31:2], 2'b00};
   assign mem_wdata = r_wdata;
   assign st_done   = r_done;
   assign st_err    = r_err;

endmodule
